task_scheduler: RTL and testbench
=================================

Name: task_scheduler

Overview:
- Distributes the task stream from the task manager across N_PE processing engines, one task per engine at a time.
- Picks an idle engine round-robin and issues a one-cycle start with the task ID.
- Tracks each engine's run/done state and returns one completion record per task through a valid/ready completion port.
- Sits between the task manager's task_id/task_valid/task_ready output and the engine array.

Parameters:
- N_PE, 4, number of engines; legal range 2..16.
- ID_W, 32, task ID width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles. Used only when TASK_SCHED_TIMEOUT_EN is defined.
- Derived localparam IDX_W = $clog2(N_PE).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  dispatch enable. When low, no new tasks are accepted; in-flight tasks still complete.
- task_id  in  ID_W  incoming task ID.
- task_valid  in  1  incoming task valid.
- task_ready  out  1  scheduler can accept a task this cycle.
- pe_start  out  N_PE  one-hot, one-cycle start pulse to the engine.
- pe_task_id  out  ID_W  task ID for the engine; valid while pe_start is nonzero.
- pe_done  in  N_PE  per-engine one-cycle completion pulse.
- busy_mask  out  N_PE  engine i is in RUN or DONE.
- outstanding  out  IDX_W+1  popcount(busy_mask).
- cpl_valid  out  1  completion record valid.
- cpl_ready  in  1  completion consumer ready.
- cpl_task_id  out  ID_W  ID of the completed task.
- cpl_pe  out  IDX_W  index of the engine that ran the task.
- cpl_timeout  out  1  completion was forced by the watchdog.

Behaviour:
- Reset values (async, rst_n low):
  - All outputs 0, except task_ready, which is combinational and therefore 0 during reset.
  - Engine states PE_IDLE; rr_ptr = 0; completion slot empty.
  - Reset mid-operation discards all in-flight tasks. No completion is emitted for them.
- Per-engine FSM:
  - PE_IDLE -> PE_RUN when dispatched.
  - PE_RUN -> PE_DONE on pe_done[i] (or on watchdog expiry).
  - PE_DONE -> PE_IDLE when its completion record is popped (cpl_valid && cpl_ready).
  - pe_done[i] is ignored in PE_IDLE and PE_DONE. No double completion is possible.
- Accepting tasks:
  - task_ready = enable && (some engine in PE_IDLE). Combinational from registered state only; it does not depend on task_valid.
  - A task is accepted on task_valid && task_ready in cycle T.
  - Selected engine = first PE_IDLE index searching upward from rr_ptr, wrapping modulo N_PE.
- Dispatch timing:
  - At the edge ending T: the engine enters PE_RUN and its ID is stored in id_reg[sel].
  - pe_start[sel]=1 and pe_task_id=task_id during T+1 (one cycle only).
  - rr_ptr <= (sel+1) mod N_PE, wrapping from N_PE-1 to 0.
  - At most one dispatch per cycle.
- Completion slot (single register):
  - Candidate set = engines in PE_DONE not yet loaded, plus engines in PE_RUN with pe_done this cycle.
  - When the slot is empty, or is being popped this cycle, it loads the lowest-index candidate. The engine being popped is excluded from candidates.
  - Minimum latency: pe_done at cycle T gives cpl_valid in T+1.
  - cpl_valid, cpl_task_id, cpl_pe and cpl_timeout hold stable until popped. Back-to-back pops give one record per cycle.
- Freeing an engine:
  - A pop at cycle T returns the engine to PE_IDLE at the T edge.
  - That engine can be redispatched in T+1.
  - A dispatch to one engine and a pop of another in the same cycle are both legal.
- Back-pressure: an engine stays busy until its record is popped, so a stalled cpl_ready eventually drops task_ready.
- enable falling mid-operation: no further accepts. Engines in RUN and DONE complete and retire normally.
- Width rules: outstanding counts 0..N_PE without overflow; cpl_pe is a binary index.

Optional Feature:
- Macro: TASK_SCHED_TIMEOUT_EN.
- Defined:
  - Each engine has a cycle counter, cleared on dispatch and incremented while in PE_RUN.
  - When the counter reaches TIMEOUT_CYC-1 without pe_done, the engine is forced to PE_DONE with a timeout flag.
  - Its record carries cpl_timeout=1.
  - If pe_done arrives in the same cycle as expiry, the normal completion wins (cpl_timeout=0).
  - A later pe_done from that engine, arriving while it is in DONE or IDLE, is ignored.
- Undefined: no counters are built, cpl_timeout is tied to 0, and TIMEOUT_CYC is unused.

Decomposition:
- Shared header npu_definitions.vh:
  - Engine state encodings PE_IDLE=2'd0, PE_RUN=2'd1, PE_DONE=2'd2.
  - Defaults for N_PE and ID_W.
- Sub-module task_rr_arbiter: N-way round-robin pick from an idle mask and rr_ptr, producing a one-hot grant, a binary index and an any flag. It is reused for the completion picker with the pointer tied to 0, which gives lowest-index priority.

Test Plan:
- Basic dispatch: N_PE=4, IDs 0x10,0x11,0x12,0x13 back-to-back, no pe_done -> pe_start 0001,0010,0100,1000 in consecutive cycles; task_ready=0 after the 4th accept; outstanding=4.
- Completion and redispatch: pe_done[2] while cpl_ready=1 -> next cycle cpl_valid=1, cpl_task_id=0x12, cpl_pe=2. Then ID 0x20 -> dispatched to engine 2 with pe_start=0100.
- Simultaneous done: pe_done=1010 in one cycle with cpl_ready held 0 for 3 cycles -> cpl_pe=1 held stable for those cycles. Raising cpl_ready then gives cpl_pe=1 then cpl_pe=3 on consecutive cycles.
- Round-robin skip/wrap: engines 0 and 3 busy, rr_ptr=3 -> the next task goes to engine 1, not 0; rr_ptr=2 afterwards.
- enable low with a task pending -> task_ready=0 and no pe_start. An in-flight pe_done still yields a completion. enable high -> dispatch resumes.
- Reset and timeout: assert rst_n mid-run with busy_mask=1111 -> all outputs 0 and no completions afterwards. With TASK_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, give no pe_done -> cpl_valid with cpl_timeout=1 exactly 8 cycles after pe_start.

Source files
------------

// File: rtl/task_scheduler_pkg.sv
// Shared engine-state encoding, default sizes and index helper for the task scheduler.
package task_scheduler_pkg;

  typedef enum logic [1:0] {
    PE_IDLE = 2'd0,
    PE_RUN  = 2'd1,
    PE_DONE = 2'd2
  } pe_state_e;

  localparam int N_PE_DEFAULT        = 4;
  localparam int ID_W_DEFAULT        = 32;
  localparam int TIMEOUT_CYC_DEFAULT = 1024;

  // Successor of an engine index, wrapping from n-1 back to 0.
  function automatic int next_index(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/task_rr_arbiter.sv
// N-way round-robin picker: first requester at or above ptr, wrapping modulo N.
// With ptr tied to zero it degenerates to a lowest-index priority picker.
module task_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  int j;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any_req && req[j]) begin
        any_req  = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/task_scheduler.sv
// Round-robin task dispatcher for an engine array with a single-entry completion slot.
// A per-engine watchdog is built only when TASK_SCHED_TIMEOUT_EN is defined.
module task_scheduler
  import task_scheduler_pkg::*;
#(
  parameter int  N_PE        = N_PE_DEFAULT,
  parameter int  ID_W        = ID_W_DEFAULT,
  parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  localparam int IDX_W       = $clog2(N_PE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ID_W-1:0]   task_id,
  input  logic              task_valid,
  output logic              task_ready,
  output logic [N_PE-1:0]   pe_start,
  output logic [ID_W-1:0]   pe_task_id,
  input  logic [N_PE-1:0]   pe_done,
  output logic [N_PE-1:0]   busy_mask,
  output logic [IDX_W:0]    outstanding,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [ID_W-1:0]   cpl_task_id,
  output logic [IDX_W-1:0]  cpl_pe,
  output logic              cpl_timeout
);

  localparam int OUT_W = IDX_W + 1;

  pe_state_e        pe_state_q [N_PE];
  pe_state_e        pe_state_d [N_PE];
  logic [ID_W-1:0]  id_reg_q   [N_PE];
  logic [ID_W-1:0]  id_reg_d   [N_PE];
  logic [N_PE-1:0]  loaded_q, loaded_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_PE-1:0]  pe_start_q, pe_start_d;
  logic [ID_W-1:0]  pe_task_id_q, pe_task_id_d;
  logic             cpl_valid_q, cpl_valid_d;
  logic [ID_W-1:0]  cpl_task_id_q, cpl_task_id_d;
  logic [IDX_W-1:0] cpl_pe_q, cpl_pe_d;
  logic             cpl_timeout_q, cpl_timeout_d;

  logic [N_PE-1:0]  idle_mask, run_mask, done_mask;
  logic [N_PE-1:0]  finish, expire, cand, cand_timeout;
  logic [N_PE-1:0]  disp_grant, cpl_grant;
  logic [IDX_W-1:0] disp_idx, cpl_idx;
  logic             disp_any, cpl_any;
  logic             accept, pop, load;

  always_comb begin
    idle_mask = '0;
    run_mask  = '0;
    done_mask = '0;
    for (int i = 0; i < N_PE; i++) begin
      idle_mask[i] = (pe_state_q[i] == PE_IDLE);
      run_mask[i]  = (pe_state_q[i] == PE_RUN);
      done_mask[i] = (pe_state_q[i] == PE_DONE);
    end
  end

  // Completion candidates: finished engines still waiting for the slot, plus engines finishing now.
  assign finish = run_mask & (pe_done | expire);
  assign cand   = (done_mask & ~loaded_q) | finish;

  task_rr_arbiter #(.N(N_PE), .IDX_W(IDX_W)) u_disp_arb (
    .req     (idle_mask),
    .ptr     (rr_ptr_q),
    .grant   (disp_grant),
    .idx     (disp_idx),
    .any_req (disp_any)
  );

  task_rr_arbiter #(.N(N_PE), .IDX_W(IDX_W)) u_cpl_arb (
    .req     (cand),
    .ptr     ({IDX_W{1'b0}}),
    .grant   (cpl_grant),
    .idx     (cpl_idx),
    .any_req (cpl_any)
  );

  assign task_ready = rst_n && enable && disp_any;
  assign accept     = task_valid && task_ready;
  assign pop        = cpl_valid_q && cpl_ready;
  assign load       = (!cpl_valid_q || pop) && cpl_any;

`ifdef TASK_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt_q [N_PE];
  logic [CNT_W-1:0] tmo_cnt_d [N_PE];
  logic [N_PE-1:0]  tmo_flag_q, tmo_flag_d;

  // A pe_done in the expiry cycle wins, so expiry is masked by pe_done.
  always_comb begin
    expire       = '0;
    cand_timeout = '0;
    tmo_flag_d   = tmo_flag_q;
    for (int i = 0; i < N_PE; i++) begin
      tmo_cnt_d[i] = tmo_cnt_q[i];
      expire[i]    = run_mask[i] && !pe_done[i] &&
                     (tmo_cnt_q[i] == CNT_W'(TIMEOUT_CYC - 1));
      if (accept && disp_grant[i]) begin
        tmo_cnt_d[i]  = '0;
        tmo_flag_d[i] = 1'b0;
      end else if (run_mask[i]) begin
        tmo_cnt_d[i] = tmo_cnt_q[i] + 1'b1;
        if (expire[i]) tmo_flag_d[i] = 1'b1;
      end
      cand_timeout[i] = expire[i] | (done_mask[i] & tmo_flag_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_flag_q <= '0;
      for (int i = 0; i < N_PE; i++) tmo_cnt_q[i] <= '0;
    end else begin
      tmo_flag_q <= tmo_flag_d;
      for (int i = 0; i < N_PE; i++) tmo_cnt_q[i] <= tmo_cnt_d[i];
    end
  end
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign expire             = '0;
  assign cand_timeout       = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PE; i++) begin
        pe_state_q[i] <= PE_IDLE;
        id_reg_q[i]   <= '0;
      end
      loaded_q <= '0;
    end else begin
      for (int i = 0; i < N_PE; i++) begin
        pe_state_q[i] <= pe_state_d[i];
        id_reg_q[i]   <= id_reg_d[i];
      end
      loaded_q <= loaded_d;
    end
  end

  // An engine leaves DONE only when the record it owns in the slot is popped.
  always_comb begin
    loaded_d = loaded_q;
    for (int i = 0; i < N_PE; i++) begin
      pe_state_d[i] = pe_state_q[i];
      id_reg_d[i]   = id_reg_q[i];
      case (pe_state_q[i])
        PE_IDLE: begin
          if (accept && disp_grant[i]) begin
            pe_state_d[i] = PE_RUN;
            id_reg_d[i]   = task_id;
          end
        end
        PE_RUN: begin
          if (finish[i]) pe_state_d[i] = PE_DONE;
        end
        PE_DONE: begin
          if (pop && (cpl_pe_q == IDX_W'(i))) begin
            pe_state_d[i] = PE_IDLE;
            loaded_d[i]   = 1'b0;
          end
        end
        default: pe_state_d[i] = PE_IDLE;
      endcase
      if (load && cpl_grant[i]) loaded_d[i] = 1'b1;
    end
  end

  always_comb begin
    busy_mask   = ~idle_mask;
    outstanding = '0;
    for (int i = 0; i < N_PE; i++) begin
      outstanding = outstanding + OUT_W'(busy_mask[i]);
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    pe_start_d    = '0;
    pe_task_id_d  = '0;
    cpl_valid_d   = cpl_valid_q;
    cpl_task_id_d = cpl_task_id_q;
    cpl_pe_d      = cpl_pe_q;
    cpl_timeout_d = cpl_timeout_q;
    if (accept) begin
      pe_start_d   = disp_grant;
      pe_task_id_d = task_id;
      rr_ptr_d     = IDX_W'(next_index(int'(disp_idx), N_PE));
    end
    if (pop) cpl_valid_d = 1'b0;
    if (load) begin
      cpl_valid_d   = 1'b1;
      cpl_task_id_d = id_reg_q[cpl_idx];
      cpl_pe_d      = cpl_idx;
      cpl_timeout_d = cand_timeout[cpl_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      pe_start_q    <= '0;
      pe_task_id_q  <= '0;
      cpl_valid_q   <= 1'b0;
      cpl_task_id_q <= '0;
      cpl_pe_q      <= '0;
      cpl_timeout_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      pe_start_q    <= pe_start_d;
      pe_task_id_q  <= pe_task_id_d;
      cpl_valid_q   <= cpl_valid_d;
      cpl_task_id_q <= cpl_task_id_d;
      cpl_pe_q      <= cpl_pe_d;
      cpl_timeout_q <= cpl_timeout_d;
    end
  end

  assign pe_start    = pe_start_q;
  assign pe_task_id  = pe_task_id_q;
  assign cpl_valid   = cpl_valid_q;
  assign cpl_task_id = cpl_task_id_q;
  assign cpl_pe      = cpl_pe_q;
  assign cpl_timeout = cpl_timeout_q;

endmodule

// File: tb/tb_task_scheduler.sv
// Self-checking bench for task_scheduler: directed scenarios plus randomized traffic
// checked against a set-based reference model of engines and the completion slot.
module tb_task_scheduler;

  localparam int N_PE  = 4;
  localparam int ID_W  = 32;
  localparam int TMO   = 8;
  localparam int IDX_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [ID_W-1:0]   task_id = '0;
  logic              task_valid = 1'b0;
  logic              task_ready;
  logic [N_PE-1:0]   pe_start;
  logic [ID_W-1:0]   pe_task_id;
  logic [N_PE-1:0]   pe_done = '0;
  logic [N_PE-1:0]   busy_mask;
  logic [IDX_W:0]    outstanding;
  logic              cpl_valid;
  logic              cpl_ready = 1'b0;
  logic [ID_W-1:0]   cpl_task_id;
  logic [IDX_W-1:0]  cpl_pe;
  logic              cpl_timeout;

  int checks = 0;
  int errors = 0;

  task_scheduler #(.N_PE(N_PE), .ID_W(ID_W), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .task_id     (task_id),
    .task_valid  (task_valid),
    .task_ready  (task_ready),
    .pe_start    (pe_start),
    .pe_task_id  (pe_task_id),
    .pe_done     (pe_done),
    .busy_mask   (busy_mask),
    .outstanding (outstanding),
    .cpl_valid   (cpl_valid),
    .cpl_ready   (cpl_ready),
    .cpl_task_id (cpl_task_id),
    .cpl_pe      (cpl_pe),
    .cpl_timeout (cpl_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog_time got=stuck exp=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Reference model: which engines hold a task, which are still running, which have
  // finished but wait for the slot, and the record currently offered on the slot.
  bit              m_busy [N_PE];
  bit              m_run  [N_PE];
  bit              m_wait [N_PE];
  bit              m_wtmo [N_PE];
  int              m_cnt  [N_PE];
  logic [ID_W-1:0] m_id   [N_PE];
  bit              m_slot_v;
  int              m_slot_pe;
  logic [ID_W-1:0] m_slot_id;
  bit              m_slot_tmo;
  int              m_rr;
  logic [N_PE-1:0] m_start;
  logic [ID_W-1:0] m_start_id;

  function automatic void model_reset();
    for (int i = 0; i < N_PE; i++) begin
      m_busy[i] = 0; m_run[i] = 0; m_wait[i] = 0; m_wtmo[i] = 0; m_cnt[i] = 0; m_id[i] = '0;
    end
    m_slot_v = 0; m_slot_pe = 0; m_slot_id = '0; m_slot_tmo = 0;
    m_rr = 0; m_start = '0; m_start_id = '0;
  endfunction

  function automatic logic [N_PE-1:0] m_busy_vec();
    logic [N_PE-1:0] b;
    b = '0;
    for (int i = 0; i < N_PE; i++) b[i] = m_busy[i];
    return b;
  endfunction

  function automatic logic m_ready();
    return rst_n && enable && (m_busy_vec() != {N_PE{1'b1}});
  endfunction

  function automatic logic [12:0] m_vec();
    logic [N_PE-1:0] b;
    b = m_busy_vec();
    return {m_ready(), m_start, b, 3'($countones(b)), m_slot_v};
  endfunction

  function automatic logic [ID_W+IDX_W:0] m_cpl();
    return {m_slot_id, IDX_W'(m_slot_pe), m_slot_tmo};
  endfunction

  // Advance the model by one clock using the inputs presented this cycle.
  function automatic void model_step();
    int sel;
    bit accept;
    bit pop;
    bit tfin [N_PE];
    bit fin  [N_PE];
    sel = -1;
    if (rst_n && enable)
      for (int k = 0; k < N_PE; k++)
        if (sel < 0 && !m_busy[(m_rr + k) % N_PE]) sel = (m_rr + k) % N_PE;
    accept = task_valid && (sel >= 0);
    pop    = m_slot_v && cpl_ready;
    for (int i = 0; i < N_PE; i++) begin
      tfin[i] = 0;
`ifdef TASK_SCHED_TIMEOUT_EN
      tfin[i] = m_run[i] && !pe_done[i] && (m_cnt[i] == TMO - 1);
`endif
      fin[i] = m_run[i] && (pe_done[i] || tfin[i]);
    end
    if (pop) begin
      m_busy[m_slot_pe] = 0;
      m_slot_v = 0;
    end
    for (int i = 0; i < N_PE; i++) begin
      if (fin[i]) begin
        m_run[i] = 0; m_wait[i] = 1; m_wtmo[i] = tfin[i];
      end else if (m_run[i]) begin
        m_cnt[i]++;
      end
    end
    if (!m_slot_v)
      for (int i = 0; i < N_PE; i++)
        if (!m_slot_v && m_wait[i]) begin
          m_slot_v = 1; m_slot_pe = i; m_slot_id = m_id[i]; m_slot_tmo = m_wtmo[i];
          m_wait[i] = 0;
        end
    m_start = '0;
    if (accept) begin
      m_busy[sel] = 1; m_run[sel] = 1; m_id[sel] = task_id; m_cnt[sel] = 0;
      m_start[sel] = 1'b1; m_start_id = task_id;
      m_rr = (sel + 1) % N_PE;
    end
  endfunction

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic tv, input logic [ID_W-1:0] id, input logic en,
                       input logic [N_PE-1:0] done, input logic cr);
    task_valid = tv; task_id = id; enable = en; pe_done = done; cpl_ready = cr;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; task_valid = 1'b0; enable = 1'b0; pe_done = '0; cpl_ready = 1'b0; task_id = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; task_valid = 1'b1; task_id = 32'hdead_beef;
    model_reset();
    #1;
    checks++;
    if ({task_ready, pe_start, pe_task_id, busy_mask, outstanding, cpl_valid, cpl_task_id, cpl_pe, cpl_timeout} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b/%h/%h/%h/%0d/%b/%h/%0d/%b exp=all zero",
               task_ready, pe_start, pe_task_id, busy_mask, outstanding, cpl_valid, cpl_task_id, cpl_pe, cpl_timeout);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    task_valid = 1'b0;
  endtask

  task automatic test_basic_dispatch();
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, ID_W'(32'h10 + k), 1'b1, '0, 1'b1);
      checks++;
      if ({task_ready, pe_start, busy_mask, outstanding, cpl_valid} !== m_vec()) begin
        errors++;
        $display("[TB] FAIL basic_ctrl cyc=%0d got=%h exp=%h", k, {task_ready, pe_start, busy_mask, outstanding, cpl_valid}, m_vec());
      end
      if (k > 0) begin
        checks++;
        if (pe_start !== N_PE'(1 << (k - 1)) || pe_task_id !== ID_W'(32'h10 + k - 1)) begin
          errors++;
          $display("[TB] FAIL basic_start cyc=%0d got=%b/%h exp=%b/%h", k, pe_start, pe_task_id, N_PE'(1 << (k - 1)), 32'h10 + k - 1);
        end
      end
      if (k == 4) begin
        checks++;
        if (task_ready !== 1'b0 || outstanding !== 3'd4) begin
          errors++;
          $display("[TB] FAIL basic_full got=%b/%0d exp=0/4", task_ready, outstanding);
        end
      end
      advance();
    end
  endtask

  task automatic test_complete_redispatch();
    for (int k = 0; k < 4; k++) begin
      drive(k == 2, ID_W'(32'h20), 1'b1, (k == 0) ? 4'b0100 : 4'b0000, 1'b1);
      checks++;
      if ({task_ready, pe_start, busy_mask, outstanding, cpl_valid} !== m_vec()) begin
        errors++;
        $display("[TB] FAIL redisp_ctrl cyc=%0d got=%h exp=%h", k, {task_ready, pe_start, busy_mask, outstanding, cpl_valid}, m_vec());
      end
      if (k == 1) begin
        checks++;
        if ({cpl_valid, cpl_task_id, cpl_pe, cpl_timeout} !== {1'b1, 32'h12, 2'd2, 1'b0}) begin
          errors++;
          $display("[TB] FAIL redisp_cpl got=%b/%h/%0d/%b exp=1/12/2/0", cpl_valid, cpl_task_id, cpl_pe, cpl_timeout);
        end
      end
      if (k == 3) begin
        checks++;
        if (pe_start !== 4'b0100 || pe_task_id !== 32'h20) begin
          errors++;
          $display("[TB] FAIL redisp_start got=%b/%h exp=0100/20", pe_start, pe_task_id);
        end
      end
      advance();
    end
  endtask

  task automatic test_simultaneous_done();
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, '0, 1'b1, (k == 0) ? 4'b1010 : 4'b0000, k >= 4);
      checks++;
      if ({task_ready, pe_start, busy_mask, outstanding, cpl_valid} !== m_vec()) begin
        errors++;
        $display("[TB] FAIL simul_ctrl cyc=%0d got=%h exp=%h", k, {task_ready, pe_start, busy_mask, outstanding, cpl_valid}, m_vec());
      end
      if (k >= 1 && k <= 5) begin
        checks++;
        if ({cpl_valid, cpl_pe, cpl_task_id} !== ((k == 5) ? {1'b1, 2'd3, 32'h13} : {1'b1, 2'd1, 32'h11})) begin
          errors++;
          $display("[TB] FAIL simul_cpl cyc=%0d got=%b/%0d/%h exp=1/%0d", k, cpl_valid, cpl_pe, cpl_task_id, (k == 5) ? 3 : 1);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, ID_W'(32'h70 + k), 1'b1, (k == 2) ? 4'b0001 : 4'b0000, 1'b0);
      checks++;
      if ({task_ready, pe_start, busy_mask, outstanding, cpl_valid} !== m_vec()) begin
        errors++;
        $display("[TB] FAIL midrst_ctrl cyc=%0d got=%h exp=%h", k, {task_ready, pe_start, busy_mask, outstanding, cpl_valid}, m_vec());
      end
      if (k < 4) advance();
    end
    checks++;
    if (busy_mask !== 4'hf || cpl_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pre got=%b/%b exp=1111/1", busy_mask, cpl_valid);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({task_ready, pe_start, pe_task_id, busy_mask, outstanding, cpl_valid, cpl_task_id, cpl_pe, cpl_timeout} !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs got=%b/%b/%h/%b/%0d/%b exp=all zero", task_ready, pe_start, pe_task_id, busy_mask, outstanding, cpl_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, '0, 1'b1, N_PE'($urandom), 1'b1);
      checks++;
      if (cpl_valid !== 1'b0 || busy_mask !== 4'h0) begin
        errors++;
        $display("[TB] FAIL midrst_after cyc=%0d got=%b/%b exp=0/0000", k, cpl_valid, busy_mask);
      end
      advance();
    end
  endtask

  task automatic test_rr_wrap();
    logic [N_PE-1:0] dn;
    logic tv;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      tv = (k < 4) || (k == 7) || (k == 8) || (k == 12) || (k == 13);
      dn = (k == 4 || k == 9) ? 4'b0110 : 4'b0000;
      drive(tv, ID_W'(32'h40 + k), 1'b1, dn, 1'b1);
      checks++;
      if ({task_ready, pe_start, busy_mask, outstanding, cpl_valid} !== m_vec()) begin
        errors++;
        $display("[TB] FAIL rr_ctrl cyc=%0d got=%h exp=%h", k, {task_ready, pe_start, busy_mask, outstanding, cpl_valid}, m_vec());
      end
      if (k == 13 || k == 14) begin
        checks++;
        if (pe_start !== ((k == 13) ? 4'b0010 : 4'b0100)) begin
          errors++;
          $display("[TB] FAIL rr_skip cyc=%0d got=%b exp=%b", k, pe_start, (k == 13) ? 4'b0010 : 4'b0100);
        end
      end
      advance();
    end
  endtask

  task automatic test_enable_low();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(k < 5, (k == 0) ? ID_W'(32'h50) : ID_W'(32'h51), (k == 0) || (k == 4),
            (k == 2) ? 4'b0001 : 4'b0000, 1'b1);
      checks++;
      if ({task_ready, pe_start, busy_mask, outstanding, cpl_valid} !== m_vec()) begin
        errors++;
        $display("[TB] FAIL enable_ctrl cyc=%0d got=%h exp=%h", k, {task_ready, pe_start, busy_mask, outstanding, cpl_valid}, m_vec());
      end
      if (k >= 2 && k <= 4) begin
        checks++;
        if (task_ready !== (k == 4) || pe_start !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL enable_gate cyc=%0d got=%b/%b exp=%b/0000", k, task_ready, pe_start, k == 4);
        end
      end
      if (k == 3) begin
        checks++;
        if ({cpl_valid, cpl_task_id, cpl_pe} !== {1'b1, 32'h50, 2'd0}) begin
          errors++;
          $display("[TB] FAIL enable_cpl got=%b/%h/%0d exp=1/50/0", cpl_valid, cpl_task_id, cpl_pe);
        end
      end
      if (k == 5) begin
        checks++;
        if (pe_start !== 4'b0010 || pe_task_id !== 32'h51) begin
          errors++;
          $display("[TB] FAIL enable_resume got=%b/%h exp=0010/51", pe_start, pe_task_id);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [N_PE-1:0] dn;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      dn = '0;
      for (int i = 0; i < N_PE; i++) dn[i] = ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) != 0, dn, $urandom_range(0, 9) < 6);
      checks++;
      if ({task_ready, pe_start, busy_mask, outstanding, cpl_valid} !== m_vec()) begin
        errors++;
        $display("[TB] FAIL rand_ctrl cyc=%0d got=%h exp=%h", k, {task_ready, pe_start, busy_mask, outstanding, cpl_valid}, m_vec());
      end
      if (m_slot_v) begin
        checks++;
        if ({cpl_task_id, cpl_pe, cpl_timeout} !== m_cpl()) begin
          errors++;
          $display("[TB] FAIL rand_cpl cyc=%0d got=%h exp=%h", k, {cpl_task_id, cpl_pe, cpl_timeout}, m_cpl());
        end
      end
      if (m_start != '0) begin
        checks++;
        if (pe_task_id !== m_start_id) begin
          errors++;
          $display("[TB] FAIL rand_start_id cyc=%0d got=%h exp=%h", k, pe_task_id, m_start_id);
        end
      end
      advance();
    end
  endtask

`ifdef TASK_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int st;
    int fc;
    do_reset();
    st = -1;
    fc = -1;
    for (int k = 0; k < 15; k++) begin
      drive(k == 0, ID_W'(32'h60), 1'b1, (k == 11 || k == 13) ? 4'b0001 : 4'b0000, k == 12);
      checks++;
      if ({task_ready, pe_start, busy_mask, outstanding, cpl_valid} !== m_vec()) begin
        errors++;
        $display("[TB] FAIL tmo_ctrl cyc=%0d got=%h exp=%h", k, {task_ready, pe_start, busy_mask, outstanding, cpl_valid}, m_vec());
      end
      if (pe_start != '0 && st < 0) st = k;
      if (cpl_valid === 1'b1 && fc < 0) begin
        fc = k;
        checks++;
        if ({cpl_task_id, cpl_pe, cpl_timeout} !== {32'h60, 2'd0, 1'b1}) begin
          errors++;
          $display("[TB] FAIL tmo_record got=%h/%0d/%b exp=60/0/1", cpl_task_id, cpl_pe, cpl_timeout);
        end
      end
      if (k == 14) begin
        checks++;
        if (cpl_valid !== 1'b0 || busy_mask !== 4'h0) begin
          errors++;
          $display("[TB] FAIL tmo_late_done got=%b/%b exp=0/0000", cpl_valid, busy_mask);
        end
      end
      advance();
    end
    checks++;
    if (st < 0 || fc < 0 || (fc - st) != TMO) begin
      errors++;
      $display("[TB] FAIL tmo_latency got=start %0d cpl %0d exp=distance %0d", st, fc, TMO);
    end
    for (int k = 0; k < 11; k++) begin
      drive(k == 0, ID_W'(32'h61), 1'b1, (k == 8) ? 4'b0010 : 4'b0000, k >= 9);
      checks++;
      if ({task_ready, pe_start, busy_mask, outstanding, cpl_valid} !== m_vec()) begin
        errors++;
        $display("[TB] FAIL tmo_race_ctrl cyc=%0d got=%h exp=%h", k, {task_ready, pe_start, busy_mask, outstanding, cpl_valid}, m_vec());
      end
      if (k == 9) begin
        checks++;
        if ({cpl_valid, cpl_pe, cpl_task_id, cpl_timeout} !== {1'b1, 2'd1, 32'h61, 1'b0}) begin
          errors++;
          $display("[TB] FAIL tmo_race got=%b/%0d/%h/%b exp=1/1/61/0", cpl_valid, cpl_pe, cpl_task_id, cpl_timeout);
        end
      end
      advance();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_dispatch();
    test_complete_redispatch();
    test_simultaneous_done();
    test_reset_midrun();
    test_rr_wrap();
    test_enable_low();
    test_random();
`ifdef TASK_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
